// File: rtl/clk_tick_pkg.sv
// Shared constants and state encoding for the clock-enable tick generator.
package clk_tick_pkg;

   localparam int DEF_CNT_W = 26;
   localparam int DIV_1HZ   = 50_000_000;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tick_state_e;

endpackage

// File: rtl/clk_tick_chan.sv
// One tick channel: IDLE/RUN FSM, down-counter, tick and square-wave outputs.
module clk_tick_chan
   import clk_tick_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_div,
   input  logic             i_sync,
   output logic             o_tick,
   output logic             o_sq,
   output logic             o_busy
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   tick_state_e      r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_div_act, w_div_nxt;
   logic             r_sq, w_sq_nxt;
   logic             w_upd;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_div_act <= '0;
         r_sq      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_div_act <= w_div_nxt;
         r_sq      <= w_sq_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_div_nxt   = r_div_act;
      w_sq_nxt    = r_sq;
      w_upd       = 1'b0;
      case (r_state)
         IDLE: begin
            w_sq_nxt = 1'b0;
            if (i_en && (i_div != '0)) begin
               w_state_nxt = RUN;
               w_div_nxt   = i_div;
               w_cnt_nxt   = i_div - ONE;
               w_upd       = 1'b1;
            end
         end
         RUN: begin
            // Phase realign beats both the terminal count and a paused channel
            if (i_sync) begin
               w_cnt_nxt = r_div_act - ONE;
               w_upd     = 1'b1;
            end else if (i_en) begin
               if (r_cnt == '0) begin
                  if (i_div == '0) begin
                     w_state_nxt = IDLE;
                     w_sq_nxt    = 1'b0;
                  end else begin
                     w_div_nxt = i_div;
                     w_cnt_nxt = i_div - ONE;
                     w_upd     = 1'b1;
                  end
               end else begin
                  w_cnt_nxt = r_cnt - ONE;
                  w_upd     = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_upd)
         w_sq_nxt = (w_cnt_nxt >= (w_div_nxt >> 1));
   end

   // Gated by the live en/sync so a pause or realign landing on terminal count suppresses the tick
   assign o_tick = (r_state == RUN) && (r_cnt == '0) && i_en && !i_sync;
   assign o_sq   = r_sq;
   assign o_busy = (r_state == RUN);

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable generator; one clk_tick_chan per channel.
// Define TICK_SYNC_EN to add the sync_i phase-realign strobe shared by all channels.
module clk_tick_gen
   import clk_tick_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    clk_50MHz,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       en_i,
   input  logic [NUM_CH*CNT_W-1:0] div_i,
`ifdef TICK_SYNC_EN
   input  logic                    sync_i,
`endif
   output logic [NUM_CH-1:0]       tick_o,
   output logic [NUM_CH-1:0]       sq_o,
   output logic [NUM_CH-1:0]       busy_o
);

   logic w_sync;

`ifdef TICK_SYNC_EN
   assign w_sync = sync_i;
`else
   assign w_sync = 1'b0;
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      clk_tick_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .i_clk   (clk_50MHz),
         .i_rst_n (rst_n),
         .i_en    (en_i[k]),
         .i_div   (div_i[k*CNT_W +: CNT_W]),
         .i_sync  (w_sync),
         .o_tick  (tick_o[k]),
         .o_sq    (sq_o[k]),
         .o_busy  (busy_o[k])
      );
   end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen (2 channels); sync section built only with TICK_SYNC_EN.
module tb_clk_tick_gen;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 26;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_CH-1:0]       en_i;
   logic [NUM_CH*CNT_W-1:0] div_i;
`ifdef TICK_SYNC_EN
   logic                    sync_i;
`endif
   logic [NUM_CH-1:0]       tick_o, sq_o, busy_o;

   int n_vec = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   clk_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk_50MHz (clk),
      .rst_n     (rst_n),
      .en_i      (en_i),
      .div_i     (div_i),
`ifdef TICK_SYNC_EN
      .sync_i    (sync_i),
`endif
      .tick_o    (tick_o),
      .sq_o      (sq_o),
      .busy_o    (busy_o)
   );

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed {tick,sq,busy}=%b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then check 1 time unit later.
   task automatic step(input logic [1:0] en, input logic [CNT_W-1:0] d0, input logic [CNT_W-1:0] d1,
                       input logic [1:0] xt, input logic [1:0] xs, input logic [1:0] xb,
                       input string tag);
      @(negedge clk);
      en_i  = en;
      div_i = {d1, d0};
      #1;
      chk(tag, {tick_o, sq_o, busy_o}, {xt, xs, xb});
   endtask

   initial begin
      logic t0, t1, s0, s1;
      rst_n = 1'b0;
      en_i  = '0;
      div_i = '0;
`ifdef TICK_SYNC_EN
      sync_i = 1'b0;
`endif
      repeat (2) @(negedge clk);
      #1 chk("reset", {tick_o, sq_o, busy_o}, 6'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // ch0 div=4, ch1 div=5 from the same load cycle
      step(2'b11, 4, 5, 2'b00, 2'b00, 2'b00, "load");
      for (int i = 1; i <= 10; i++) begin
         t0 = (i % 4 == 0);
         s0 = (i % 4 == 1) || (i % 4 == 2);
         t1 = (i % 5 == 0);
         s1 = (i % 5 >= 1) && (i % 5 <= 3);
         if (i == 10)  // ch0 -> 6 mid-period, ch1 -> 0 at its terminal count
            step(2'b11, 6, 0, {t1, t0}, {s1, s0}, 2'b11, $sformatf("run%0d", i));
         else
            step(2'b11, 4, 5, {t1, t0}, {s1, s0}, 2'b11, $sformatf("run%0d", i));
      end

      // ch0 finishes its 4-period then runs 6; ch1 parked in IDLE
      step(2'b11, 6, 0, 2'b00, 2'b00, 2'b01, "chg11");
      step(2'b11, 6, 0, 2'b01, 2'b00, 2'b01, "chg12");
      step(2'b11, 6, 0, 2'b00, 2'b01, 2'b01, "chg13");
      step(2'b11, 6, 0, 2'b00, 2'b01, 2'b01, "chg14");
      step(2'b11, 6, 0, 2'b00, 2'b01, 2'b01, "chg15");
      step(2'b11, 6, 0, 2'b00, 2'b00, 2'b01, "chg16");
      step(2'b11, 6, 0, 2'b00, 2'b00, 2'b01, "chg17");
      step(2'b11, 4, 0, 2'b01, 2'b00, 2'b01, "chg18");

      // back to div=4, then pause for 3 cycles exactly at terminal count
      step(2'b11, 4, 0, 2'b00, 2'b01, 2'b01, "en19");
      step(2'b11, 4, 0, 2'b00, 2'b01, 2'b01, "en20");
      step(2'b11, 4, 0, 2'b00, 2'b00, 2'b01, "en21");
      step(2'b10, 4, 0, 2'b00, 2'b00, 2'b01, "pause22");
      step(2'b10, 4, 0, 2'b00, 2'b00, 2'b01, "pause23");
      step(2'b10, 4, 0, 2'b00, 2'b00, 2'b01, "pause24");
      step(2'b11, 4, 0, 2'b01, 2'b00, 2'b01, "resume25");
      step(2'b11, 4, 0, 2'b00, 2'b01, 2'b01, "res26");
      step(2'b11, 4, 0, 2'b00, 2'b01, 2'b01, "res27");
      step(2'b11, 4, 0, 2'b00, 2'b00, 2'b01, "res28");
      step(2'b11, 4, 1, 2'b01, 2'b00, 2'b01, "res29");

      // ch1 div=1: tick every cycle, sq stuck high
      step(2'b11, 4, 1, 2'b10, 2'b11, 2'b11, "div1_30");
      step(2'b11, 4, 1, 2'b10, 2'b11, 2'b11, "div1_31");
      step(2'b11, 4, 1, 2'b10, 2'b10, 2'b11, "div1_32");
      step(2'b11, 4, 1, 2'b11, 2'b10, 2'b11, "div1_33");

      // asynchronous reset in mid-cycle, away from any rising edge
      @(negedge clk);
      #3 rst_n = 1'b0;
      en_i = 2'b00;
      #1 chk("async_rst", {tick_o, sq_o, busy_o}, 6'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(2'b00, 4, 1, 2'b00, 2'b00, 2'b00, "idle_rst1");
      step(2'b00, 4, 1, 2'b00, 2'b00, 2'b00, "idle_rst2");

`ifdef TICK_SYNC_EN
      // ch0 div=4 and ch1 div=8 started out of phase, then realigned
      step(2'b01, 4, 8, 2'b00, 2'b00, 2'b00, "sy_a0");
      step(2'b11, 4, 8, 2'b00, 2'b01, 2'b01, "sy_a1");
      step(2'b11, 4, 8, 2'b00, 2'b11, 2'b11, "sy_a2");
      step(2'b11, 4, 8, 2'b00, 2'b10, 2'b11, "sy_a3");
      @(negedge clk);
      sync_i = 1'b1;
      #1 chk("sy_pulse", {tick_o, sq_o, busy_o}, {2'b00, 2'b10, 2'b11});
      @(negedge clk);
      sync_i = 1'b0;
      #1 chk("sy_k1", {tick_o, sq_o, busy_o}, {2'b00, 2'b11, 2'b11});
      for (int k = 2; k <= 16; k++) begin
         t0 = (k % 4 == 0);
         s0 = (k % 4 == 1) || (k % 4 == 2);
         t1 = (k % 8 == 0);
         s1 = (k % 8 >= 1) && (k % 8 <= 4);
         step(2'b11, 4, 8, {t1, t0}, {s1, s0}, 2'b11, $sformatf("sy_k%0d", k));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
